// File: rtl/ebu_ahb_arbiter.sv
// AHB-Lite manager-port arbiter between the IFU (read-only) and the LSU for the external bus unit.
// Optional EBU_ROUNDROBIN_EN: alternate the winner on a both-request tie instead of fixed LSU priority.
module ebu_ahb_arbiter #(
    parameter int unsigned PA_BITS  = 56,
    parameter int unsigned AHBW     = 64,
    parameter int unsigned BURST_EN = 1,
    parameter int unsigned BEATW    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               IFUReq,
    input  logic [PA_BITS-1:0] IFUAddr,
    input  logic [BEATW-1:0]   IFUBeats,
    input  logic               LSUReq,
    input  logic               LSUWrite,
    input  logic [PA_BITS-1:0] LSUAddr,
    input  logic [BEATW-1:0]   LSUBeats,
    input  logic               HREADY,
    output logic [PA_BITS-1:0] HADDR,
    output logic               HWRITE,
    output logic [1:0]         HTRANS,
    output logic [2:0]         HBURST,
    output logic               IFUGrant,
    output logic               LSUGrant,
    output logic               IFUDone,
    output logic               LSUDone
);

    localparam int unsigned BEAT_BYTES = AHBW / 8;
    localparam logic [1:0]  TR_IDLE    = 2'b00;
    localparam logic [1:0]  TR_NONSEQ  = 2'b10;
    localparam logic [1:0]  TR_SEQ     = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_LAST} state_t;

    state_t             state_q, state_d;
    logic [PA_BITS-1:0] haddr_q, haddr_d;
    logic               hwrite_q, hwrite_d;
    logic [1:0]         htrans_q, htrans_d;
    logic [2:0]         hburst_q, hburst_d;
    logic               ifu_grant_q, ifu_grant_d;
    logic               lsu_grant_q, lsu_grant_d;
    logic [BEATW-1:0]   addr_left_q, addr_left_d;
    logic               lsu_win;

    // Burst encoding from the beats-minus-one field
    function automatic logic [2:0] burst_of(input logic [BEATW-1:0] beats_m1);
        logic [2:0] b;
        if (BURST_EN == 0) begin
            b = 3'b000;
        end else begin
            case (beats_m1)
                BEATW'(0):  b = 3'b000;
                BEATW'(3):  b = 3'b011;
                BEATW'(7):  b = 3'b101;
                BEATW'(15): b = 3'b111;
                default:    b = 3'b001;
            endcase
        end
        return b;
    endfunction

`ifdef EBU_ROUNDROBIN_EN
    logic last_lsu_q, last_lsu_d;

    // Tie-break history: who won the most recent grant
    assign lsu_win = LSUReq && !(IFUReq && last_lsu_q);

    always_comb begin
        last_lsu_d = last_lsu_q;
        if (state_q == ST_IDLE && (LSUReq || IFUReq)) begin
            last_lsu_d = lsu_win;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_lsu_q <= 1'b1;
        end else begin
            last_lsu_q <= last_lsu_d;
        end
    end
`else
    assign lsu_win = LSUReq;
`endif

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        htrans_d    = htrans_q;
        hburst_d    = hburst_q;
        ifu_grant_d = ifu_grant_q;
        lsu_grant_d = lsu_grant_q;
        addr_left_d = addr_left_q;
        case (state_q)
            ST_IDLE: begin
                if (LSUReq || IFUReq) begin
                    state_d  = ST_ADDR;
                    htrans_d = TR_NONSEQ;
                    if (lsu_win) begin
                        haddr_d     = LSUAddr;
                        hwrite_d    = LSUWrite;
                        addr_left_d = LSUBeats;
                        hburst_d    = burst_of(LSUBeats);
                        lsu_grant_d = 1'b1;
                    end else begin
                        haddr_d     = IFUAddr;
                        hwrite_d    = 1'b0;
                        addr_left_d = IFUBeats;
                        hburst_d    = burst_of(IFUBeats);
                        ifu_grant_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                // Address phase only advances when the slave accepts it
                if (HREADY) begin
                    if (addr_left_q == '0) begin
                        state_d  = ST_LAST;
                        htrans_d = TR_IDLE;
                    end else begin
                        haddr_d     = haddr_q + PA_BITS'(BEAT_BYTES);
                        addr_left_d = addr_left_q - BEATW'(1);
                        htrans_d    = (BURST_EN != 0) ? TR_SEQ : TR_NONSEQ;
                    end
                end
            end
            ST_LAST: begin
                if (HREADY) begin
                    state_d     = ST_IDLE;
                    ifu_grant_d = 1'b0;
                    lsu_grant_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            htrans_q    <= TR_IDLE;
            hburst_q    <= 3'b000;
            ifu_grant_q <= 1'b0;
            lsu_grant_q <= 1'b0;
            addr_left_q <= '0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            htrans_q    <= htrans_d;
            hburst_q    <= hburst_d;
            ifu_grant_q <= ifu_grant_d;
            lsu_grant_q <= lsu_grant_d;
            addr_left_q <= addr_left_d;
        end
    end

    assign HADDR    = haddr_q;
    assign HWRITE   = hwrite_q;
    assign HTRANS   = htrans_q;
    assign HBURST   = hburst_q;
    assign IFUGrant = ifu_grant_q;
    assign LSUGrant = lsu_grant_q;
    // Done coincides with the final data phase completing
    assign IFUDone  = (state_q == ST_LAST) && HREADY && ifu_grant_q;
    assign LSUDone  = (state_q == ST_LAST) && HREADY && lsu_grant_q;

endmodule

// File: tb/tb_ebu_ahb_arbiter.sv
// Scoreboard bench for ebu_ahb_arbiter: one burst-mode instance and one BURST_EN=0 instance.
module tb_ebu_ahb_arbiter;

    typedef struct {
        bit          is_done;
        logic [55:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic        wr;
        logic [1:0]  grant;
        int          cyc;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        IFUReq, LSUReq, LSUWrite, HREADY, lsu_req_b;
    logic [55:0] IFUAddr, LSUAddr;
    logic [3:0]  IFUBeats, LSUBeats;

    logic [55:0] haddr_a, haddr_b;
    logic        hwrite_a, hwrite_b;
    logic [1:0]  htrans_a, htrans_b;
    logic [2:0]  hburst_a, hburst_b;
    logic        igr_a, lgr_a, idn_a, ldn_a;
    logic        igr_b, lgr_b, idn_b, ldn_b;

    item_t qa[$];
    item_t qb[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    last_lsu = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ebu_ahb_arbiter #(.PA_BITS(56), .AHBW(64), .BURST_EN(1), .BEATW(4)) dut (
        .clk(clk), .reset(reset),
        .IFUReq(IFUReq), .IFUAddr(IFUAddr), .IFUBeats(IFUBeats),
        .LSUReq(LSUReq), .LSUWrite(LSUWrite), .LSUAddr(LSUAddr), .LSUBeats(LSUBeats),
        .HREADY(HREADY), .HADDR(haddr_a), .HWRITE(hwrite_a), .HTRANS(htrans_a), .HBURST(hburst_a),
        .IFUGrant(igr_a), .LSUGrant(lgr_a), .IFUDone(idn_a), .LSUDone(ldn_a)
    );

    ebu_ahb_arbiter #(.PA_BITS(56), .AHBW(64), .BURST_EN(0), .BEATW(4)) dut_nb (
        .clk(clk), .reset(reset),
        .IFUReq(1'b0), .IFUAddr(IFUAddr), .IFUBeats(IFUBeats),
        .LSUReq(lsu_req_b), .LSUWrite(LSUWrite), .LSUAddr(LSUAddr), .LSUBeats(LSUBeats),
        .HREADY(HREADY), .HADDR(haddr_b), .HWRITE(hwrite_b), .HTRANS(htrans_b), .HBURST(hburst_b),
        .IFUGrant(igr_b), .LSUGrant(lgr_b), .IFUDone(idn_b), .LSUDone(ldn_b)
    );

    task automatic check(input bit ok, input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @cyc %0d", name, got, exp, cyc);
        end
    endtask

    // Compare one instance's outputs against the head of its expectation queue
    task automatic mon(input bit inst, input logic [55:0] a, input logic [1:0] tr, input logic [2:0] bu,
                       input logic wr, input logic ig, input logic lg, input logic idn, input logic ldn);
        item_t h;
        bit    empty;
        check(!(ig && lg), "grant_onehot", {62'd0, ig, lg}, 64'd0);
        empty = inst ? (qb.size() == 0) : (qa.size() == 0);
        if (tr != 2'b00) begin
            if (empty || (inst ? qb[0].is_done : qa[0].is_done)) begin
                check(1'b0, "unexpected_beat", {6'd0, a, tr}, 64'd0);
            end else begin
                h = inst ? qb[0] : qa[0];
                n_checks++;
                if (a !== h.addr || tr !== h.trans || bu !== h.burst || wr !== h.wr ||
                    {ig, lg} !== h.grant || (HREADY && cyc != h.cyc)) begin
                    n_fail++;
                    $display("FAIL beat inst=%0d got addr=%h tr=%b bu=%b wr=%b gr=%b cyc=%0d exp addr=%h tr=%b bu=%b wr=%b gr=%b cyc=%0d",
                             inst, a, tr, bu, wr, {ig, lg}, cyc, h.addr, h.trans, h.burst, h.wr, h.grant, h.cyc);
                end
                if (HREADY) begin
                    if (inst) void'(qb.pop_front());
                    else void'(qa.pop_front());
                end
            end
        end
        if (idn || ldn) begin
            if (empty || !(inst ? qb[0].is_done : qa[0].is_done)) begin
                check(1'b0, "unexpected_done", {62'd0, idn, ldn}, 64'd0);
            end else begin
                h = inst ? qb[0] : qa[0];
                n_checks++;
                if ({idn, ldn} !== h.grant || cyc != h.cyc) begin
                    n_fail++;
                    $display("FAIL done inst=%0d got=%b cyc=%0d exp=%b cyc=%0d", inst, {idn, ldn}, cyc, h.grant, h.cyc);
                end
                if (inst) void'(qb.pop_front());
                else void'(qa.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(1'b0, haddr_a, htrans_a, hburst_a, hwrite_a, igr_a, lgr_a, idn_a, ldn_a);
            mon(1'b1, haddr_b, htrans_b, hburst_b, hwrite_b, igr_b, lgr_b, idn_b, ldn_b);
        end
    end

    // Issue one transfer; expectations are queued before the HREADY pattern is played
    task automatic xfer(input bit inst, input bit lsu, input bit wr, input logic [55:0] addr, input int nb,
                        input logic [2:0] burst, input int stall_at, input int stall_n, input int last_stall);
        bit    hr[$];
        item_t it;
        int    t;
        if (lsu) begin
            LSUWrite = wr; LSUAddr = addr; LSUBeats = 4'(nb - 1);
        end else begin
            IFUAddr = addr; IFUBeats = 4'(nb - 1);
        end
        if (inst) lsu_req_b = 1'b1;
        else if (lsu) LSUReq = 1'b1;
        else IFUReq = 1'b1;
        t = cyc;
        for (int i = 0; i < nb; i++) begin
            if (i == stall_at) repeat (stall_n) hr.push_back(1'b0);
            hr.push_back(1'b1);
            it.is_done = 1'b0;
            it.addr    = addr + 56'(8 * i);
            it.trans   = (i == 0 || inst) ? 2'b10 : 2'b11;
            it.burst   = inst ? 3'b000 : burst;
            it.wr      = lsu & wr;
            it.grant   = lsu ? 2'b01 : 2'b10;
            it.cyc     = t + hr.size();
            if (inst) qb.push_back(it); else qa.push_back(it);
        end
        repeat (last_stall) hr.push_back(1'b0);
        hr.push_back(1'b1);
        it.is_done = 1'b1;
        it.grant   = lsu ? 2'b01 : 2'b10;
        it.cyc     = t + hr.size();
        if (inst) qb.push_back(it); else qa.push_back(it);
        foreach (hr[k]) begin
            @(posedge clk); #1;
            HREADY = hr[k];
        end
        @(posedge clk); #1;
        HREADY = 1'b1;
        if (inst) lsu_req_b = 1'b0;
        else if (lsu) LSUReq = 1'b0;
        else IFUReq = 1'b0;
        if (!inst) last_lsu = lsu;
    endtask

    // Both requesters raise in the same cycle, one beat each
    task automatic tie();
        bit lw;
`ifdef EBU_ROUNDROBIN_EN
        lw = !last_lsu;
`else
        lw = 1'b1;
`endif
        if (lw) begin
            IFUAddr = 56'h4000; IFUBeats = 4'd0; IFUReq = 1'b1;
            xfer(1'b0, 1'b1, 1'b1, 56'h1000, 1, 3'b000, -1, 0, 0);
            xfer(1'b0, 1'b0, 1'b0, 56'h4000, 1, 3'b000, -1, 0, 0);
        end else begin
            LSUWrite = 1'b1; LSUAddr = 56'h1000; LSUBeats = 4'd0; LSUReq = 1'b1;
            xfer(1'b0, 1'b0, 1'b0, 56'h4000, 1, 3'b000, -1, 0, 0);
            xfer(1'b0, 1'b1, 1'b1, 56'h1000, 1, 3'b000, -1, 0, 0);
        end
    endtask

    initial begin
        item_t it;
        int    t;
        reset = 1'b1; IFUReq = 1'b0; LSUReq = 1'b0; lsu_req_b = 1'b0; LSUWrite = 1'b0;
        HREADY = 1'b1; IFUAddr = '0; LSUAddr = '0; IFUBeats = '0; LSUBeats = '0;
        #1;
        check(htrans_a == 2'b00, "rst_htrans", 64'(htrans_a), 64'd0);
        check(haddr_a == '0, "rst_haddr", 64'(haddr_a), 64'd0);
        check(hwrite_a == 1'b0, "rst_hwrite", 64'(hwrite_a), 64'd0);
        check(hburst_a == 3'b000, "rst_hburst", 64'(hburst_a), 64'd0);
        check({igr_a, lgr_a} == 2'b00, "rst_grant", 64'({igr_a, lgr_a}), 64'd0);
        check({idn_a, ldn_a} == 2'b00, "rst_done", 64'({idn_a, ldn_a}), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        xfer(1'b0, 1'b0, 1'b0, 56'h8000_0000, 4, 3'b011, -1, 0, 0);   // IFU INCR4
        xfer(1'b0, 1'b1, 1'b1, 56'h1000, 1, 3'b000, -1, 0, 2);        // LSU single, LAST stalls
        xfer(1'b0, 1'b1, 1'b0, 56'h3000, 8, 3'b101, 2, 3, 0);         // INCR8 stall at beat 2
        xfer(1'b0, 1'b1, 1'b0, 56'h5000, 3, 3'b001, -1, 0, 0);        // undefined-length INCR
        xfer(1'b0, 1'b1, 1'b1, 56'h6000, 16, 3'b111, 5, 1, 1);        // INCR16
        xfer(1'b0, 1'b0, 1'b0, 56'hFF_FFFF_FFFF_FFF8, 2, 3'b001, -1, 0, 0); // address wrap
        tie();
        tie();
        xfer(1'b1, 1'b1, 1'b1, 56'h20, 3, 3'b000, -1, 0, 0);          // BURST_EN=0 instance

        // Reset during the fourth beat of an 8-beat write
        LSUWrite = 1'b1; LSUAddr = 56'h2000; LSUBeats = 4'd7; LSUReq = 1'b1;
        t = cyc;
        for (int i = 0; i < 3; i++) begin
            it.is_done = 1'b0;
            it.addr    = 56'h2000 + 56'(8 * i);
            it.trans   = (i == 0) ? 2'b10 : 2'b11;
            it.burst   = 3'b101;
            it.wr      = 1'b1;
            it.grant   = 2'b01;
            it.cyc     = t + 1 + i;
            qa.push_back(it);
        end
        repeat (4) @(posedge clk);
        #1;
        check(htrans_a == 2'b11, "pre_rst_seq", 64'(htrans_a), 64'h3);
        #1;
        reset = 1'b1; LSUReq = 1'b0; last_lsu = 1'b1;
        #1;
        check(htrans_a == 2'b00, "midrst_htrans", 64'(htrans_a), 64'd0);
        check(lgr_a == 1'b0, "midrst_lsugrant", 64'(lgr_a), 64'd0);
        check(haddr_a == '0, "midrst_haddr", 64'(haddr_a), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(htrans_a == 2'b00, "postrst_idle", 64'(htrans_a), 64'd0);
        check({igr_a, lgr_a} == 2'b00, "postrst_grant", 64'({igr_a, lgr_a}), 64'd0);
        check(qa.size() == 0, "queue_a_drained", 64'(qa.size()), 64'd0);
        check(qb.size() == 0, "queue_b_drained", 64'(qb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
